// File: rtl/keypad_pkg.sv
// Shared types and key-index constants for the two-player keypad scan path
// and the game input decode that consumes its events.
package keypad_pkg;

   typedef enum logic [1:0] {
      S_SETTLE  = 2'd0,
      S_EVAL    = 2'd1,
      S_ADVANCE = 2'd2
   } scan_state_e;

   typedef logic [3:0] key_idx_t;

   typedef enum logic {
      PLAYER_1 = 1'b0,
      PLAYER_2 = 1'b1
   } player_e;

   typedef struct packed {
      player_e  player;
      key_idx_t key;
      logic     press;
   } key_evt_t;

   localparam key_idx_t KEY_LEFT   = 4'd4;
   localparam key_idx_t KEY_RIGHT  = 4'd6;
   localparam key_idx_t KEY_ATTACK = 4'd5;
   localparam key_idx_t KEY_SELECT = 4'd15;

   function automatic key_idx_t key_index(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer for asynchronous keypad column inputs; idles high
// because the columns are active-low with pull-ups.
module col_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // two-stage capture of the raw pins
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_r <= {WIDTH{1'b1}};
         sync_r <= {WIDTH{1'b1}};
      end else begin
         meta_r <= din;
         sync_r <= meta_r;
      end
   end

   assign dout = sync_r;

endmodule

// File: rtl/keypad_scan_scheduler.sv
// Time-shared row scanner and debouncer for the two 4x4 player keypads,
// publishing debounced bitmaps and press/release events through a one-entry slot.
module keypad_scan_scheduler
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES = 500,
   parameter int DB_COUNT      = 4,
   parameter int SETTLE_W      = $clog2(SETTLE_CYCLES + 1),
   parameter int DB_W          = $clog2(DB_COUNT + 1)
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        scan_en_i,
   output logic [3:0]  p1_row_o,
   input  logic [3:0]  p1_col_i,
   output logic [3:0]  p2_row_o,
   input  logic [3:0]  p2_col_i,
   output logic [15:0] key_state_p1_o,
   output logic [15:0] key_state_p2_o,
   output logic        evt_valid_o,
   input  logic        evt_ready_i,
   output logic        evt_player_o,
   output logic [3:0]  evt_key_o,
   output logic        evt_press_o,
   output logic        scan_round_o
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DB_COUNT - 1);

   logic [3:0] p1_col_sync_s;
   logic [3:0] p2_col_sync_s;

   col_sync #(.WIDTH(4)) u_p1_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .din    (p1_col_i),
      .dout   (p1_col_sync_s)
   );

   col_sync #(.WIDTH(4)) u_p2_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .din    (p2_col_i),
      .dout   (p2_col_sync_s)
   );

   scan_state_e         state_r;
   player_e             player_r;
   logic [1:0]          row_r;
   logic [1:0]          col_idx_r;
   logic [SETTLE_W-1:0] settle_cnt_r;
   logic [3:0]          col_sample_r;
   logic [15:0]         key_state_p1_r;
   logic [15:0]         key_state_p2_r;
   logic [DB_W-1:0]     db_cnt_r [32];
   logic                evt_valid_r;
   key_evt_t            evt_r;
   logic                scan_round_r;
   logic [3:0]          p1_row_r;
   logic [3:0]          p2_row_r;

   key_idx_t        key_s;
   logic [4:0]      cnt_idx_s;
   logic            raw_s;
   logic            state_bit_s;
   logic [3:0]      active_cols_s;
   logic [DB_W-1:0] db_cur_s;
   logic            slot_free_s;

   // decode of the key under evaluation and of the active player's columns
   always_comb begin
      key_s       = key_index(row_r, col_idx_r);
      cnt_idx_s   = {player_r == PLAYER_2, key_s};
      raw_s       = ~col_sample_r[col_idx_r];
      db_cur_s    = db_cnt_r[cnt_idx_s];
      slot_free_s = !evt_valid_r || evt_ready_i;
      if (player_r == PLAYER_2) begin
         state_bit_s   = key_state_p2_r[key_s];
         active_cols_s = p2_col_sync_s;
      end else begin
         state_bit_s   = key_state_p1_r[key_s];
         active_cols_s = p1_col_sync_s;
      end
   end

   // scan sequencer, debounce bookkeeping, event slot and row drive
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r        <= S_SETTLE;
         player_r       <= PLAYER_1;
         row_r          <= 2'd0;
         col_idx_r      <= 2'd0;
         settle_cnt_r   <= '0;
         col_sample_r   <= 4'hF;
         key_state_p1_r <= 16'h0000;
         key_state_p2_r <= 16'h0000;
         for (int i = 0; i < 32; i++) db_cnt_r[i] <= '0;
         evt_valid_r    <= 1'b0;
         evt_r.player   <= PLAYER_1;
         evt_r.key      <= 4'd0;
         evt_r.press    <= 1'b0;
         scan_round_r   <= 1'b0;
         p1_row_r       <= 4'hF;
         p2_row_r       <= 4'hF;
      end else begin
         scan_round_r <= 1'b0;
         if (evt_valid_r && evt_ready_i) evt_valid_r <= 1'b0;

         if (!scan_en_i) begin
            state_r      <= S_SETTLE;
            settle_cnt_r <= '0;
         end else begin
            case (state_r)
               S_SETTLE: begin
                  if (settle_cnt_r == SETTLE_LAST) begin
                     col_sample_r <= active_cols_s;
                     col_idx_r    <= 2'd0;
                     settle_cnt_r <= '0;
                     state_r      <= S_EVAL;
                  end else begin
                     settle_cnt_r <= settle_cnt_r + 1'b1;
                  end
               end
               S_EVAL: begin
                  // a key at threshold with a full slot holds the scan on this key
                  if (raw_s == state_bit_s || db_cur_s < DB_LAST || slot_free_s) begin
                     if (raw_s == state_bit_s) begin
                        db_cnt_r[cnt_idx_s] <= '0;
                     end else if (db_cur_s < DB_LAST) begin
                        db_cnt_r[cnt_idx_s] <= db_cur_s + 1'b1;
                     end else begin
                        db_cnt_r[cnt_idx_s] <= '0;
                        if (player_r == PLAYER_2) key_state_p2_r[key_s] <= raw_s;
                        else                      key_state_p1_r[key_s] <= raw_s;
                        evt_valid_r  <= 1'b1;
                        evt_r.player <= player_r;
                        evt_r.key    <= key_s;
                        evt_r.press  <= raw_s;
                     end
                     col_idx_r <= col_idx_r + 2'd1;
                     if (col_idx_r == 2'd3) state_r <= S_ADVANCE;
                  end
               end
               S_ADVANCE: begin
                  row_r   <= row_r + 2'd1;
                  state_r <= S_SETTLE;
                  if (row_r == 2'd3) begin
                     player_r     <= (player_r == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                     scan_round_r <= (player_r == PLAYER_2);
                  end
               end
               default: state_r <= S_SETTLE;
            endcase
         end

         if (scan_en_i && player_r == PLAYER_1) p1_row_r <= ~(4'b0001 << row_r);
         else                                   p1_row_r <= 4'hF;
         if (scan_en_i && player_r == PLAYER_2) p2_row_r <= ~(4'b0001 << row_r);
         else                                   p2_row_r <= 4'hF;
      end
   end

   assign p1_row_o       = p1_row_r;
   assign p2_row_o       = p2_row_r;
   assign key_state_p1_o = key_state_p1_r;
   assign key_state_p2_o = key_state_p2_r;
   assign evt_valid_o    = evt_valid_r;
   assign evt_player_o   = evt_r.player;
   assign evt_key_o      = evt_r.key;
   assign evt_press_o    = evt_r.press;
   assign scan_round_o   = scan_round_r;

endmodule

// File: tb/tb_keypad_scan_scheduler.sv
// Self-checking bench: round-level debounce reference model, keypad matrix model
// driven by the row strobes, directed scenarios plus randomized key patterns.
module tb_keypad_scan_scheduler;

   localparam int SC      = 4;
   localparam int DBC     = 3;
   localparam int ROW_T   = SC + 5;
   localparam int ROUND_T = 8 * ROW_T;

   logic        clk;
   logic        rst_n;
   logic        scan_en;
   logic [3:0]  p1_row, p1_col, p2_row, p2_col;
   logic [15:0] ks1, ks2;
   logic        evt_valid, evt_ready, evt_player, evt_press, scan_round;
   logic [3:0]  evt_key;

   logic [15:0] p1_keys, p2_keys;

   int total = 0;
   int bad = 0;
   int n_events = 0;

   logic       mstate [2][16];
   int         mcnt   [2][16];
   logic [5:0] exp_q[$];

   keypad_scan_scheduler #(.SETTLE_CYCLES(SC), .DB_COUNT(DBC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .scan_en_i      (scan_en),
      .p1_row_o       (p1_row),
      .p1_col_i       (p1_col),
      .p2_row_o       (p2_row),
      .p2_col_i       (p2_col),
      .key_state_p1_o (ks1),
      .key_state_p2_o (ks2),
      .evt_valid_o    (evt_valid),
      .evt_ready_i    (evt_ready),
      .evt_player_o   (evt_player),
      .evt_key_o      (evt_key),
      .evt_press_o    (evt_press),
      .scan_round_o   (scan_round)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // keypad matrix: a pressed key shorts its row strobe onto its column
   always_comb begin
      p1_col = 4'hF;
      p2_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!p1_row[r] && p1_keys[r*4+c]) p1_col[c] = 1'b0;
            if (!p2_row[r] && p2_keys[r*4+c]) p2_col[c] = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_pack(input int p);
      logic [15:0] v;
      for (int k = 0; k < 16; k++) v[k] = mstate[p][k];
      return v;
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 16; k++) begin
            mstate[p][k] = 1'b0;
            mcnt[p][k]   = 0;
         end
      exp_q.delete();
   endtask

   // one full scan round: a key flips once it has disagreed for DBC rounds in a row
   task automatic model_step(input logic [15:0] pat1, input logic [15:0] pat2);
      logic [15:0] pat;
      for (int p = 0; p < 2; p++) begin
         pat = (p == 0) ? pat1 : pat2;
         for (int k = 0; k < 16; k++) begin
            if (pat[k] == mstate[p][k]) begin
               mcnt[p][k] = 0;
            end else begin
               mcnt[p][k]++;
               if (mcnt[p][k] == DBC) begin
                  mstate[p][k] = pat[k];
                  mcnt[p][k]   = 0;
                  exp_q.push_back({1'(p), 4'(k), pat[k]});
               end
            end
         end
      end
   endtask

   // checks any transfer about to happen, then advances one clock
   task automatic tick();
      logic [5:0] e;
      if (evt_valid && evt_ready) begin
         n_events++;
         if (exp_q.size() == 0) begin
            chk("evt_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("evt", {26'd0, evt_player, evt_key, evt_press}, {26'd0, e});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(input int limit);
      int n;
      n = 0;
      while (scan_round !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      chk("pulse_wait", {31'd0, scan_round}, 32'd1);
   endtask

   // starts at a round boundary, applies a key pattern for one full round
   task automatic run_round(input logic [15:0] pat1, input logic [15:0] pat2);
      int slot;
      logic [3:0] er;
      p1_keys = pat1;
      p2_keys = pat2;
      model_step(pat1, pat2);
      for (int i = 1; i <= ROUND_T; i++) begin
         tick();
         slot = (i - 1) / ROW_T;
         er = 4'hF;
         er[slot % 4] = 1'b0;
         chk("p1_row", {28'd0, p1_row}, {28'd0, (slot < 4) ? er : 4'hF});
         chk("p2_row", {28'd0, p2_row}, {28'd0, (slot >= 4) ? er : 4'hF});
         chk("scan_round", {31'd0, scan_round}, {31'd0, i == ROUND_T});
      end
      chk("evt_drained", 32'(exp_q.size()), 32'd0);
      chk("key_state_p1", {16'd0, ks1}, {16'd0, model_pack(0)});
      chk("key_state_p2", {16'd0, ks2}, {16'd0, model_pack(1)});
   endtask

   initial begin
      logic [15:0] ra, rb;
      int hold;
      int ev0;

      rst_n = 1'b0; scan_en = 1'b0; evt_ready = 1'b1;
      p1_keys = 16'h0000; p2_keys = 16'h0000;
      model_reset();
      @(posedge clk); #1;
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("rst_p1_row", {28'd0, p1_row}, 32'hF);
      chk("rst_p2_row", {28'd0, p2_row}, 32'hF);
      chk("rst_ks1", {16'd0, ks1}, 32'd0);
      chk("rst_ks2", {16'd0, ks2}, 32'd0);
      chk("rst_valid", {31'd0, evt_valid}, 32'd0);
      chk("rst_round", {31'd0, scan_round}, 32'd0);

      // idle scanning: row sequence and round pulse
      scan_en = 1'b1;
      run_round(16'h0000, 16'h0000);
      run_round(16'h0000, 16'h0000);

      // P1 key 5 press and release
      ev0 = n_events;
      run_round(16'h0020, 16'h0000);
      run_round(16'h0020, 16'h0000);
      chk("k5_no_early", {16'd0, ks1}, 32'd0);
      run_round(16'h0020, 16'h0000);
      chk("k5_state", {16'd0, ks1}, 32'h0020);
      chk("k5_one_evt", 32'(n_events - ev0), 32'd1);
      run_round(16'h0020, 16'h0000);
      run_round(16'h0000, 16'h0000);
      run_round(16'h0000, 16'h0000);
      run_round(16'h0000, 16'h0000);
      chk("k5_release", {16'd0, ks1}, 32'd0);
      chk("k5_two_evt", 32'(n_events - ev0), 32'd2);

      // glitch on P2 key 10, twice, must never flip
      ev0 = n_events;
      run_round(16'h0000, 16'h0400);
      run_round(16'h0000, 16'h0400);
      run_round(16'h0000, 16'h0000);
      run_round(16'h0000, 16'h0400);
      run_round(16'h0000, 16'h0400);
      run_round(16'h0000, 16'h0000);
      chk("glitch_state", {16'd0, ks2}, 32'd0);
      chk("glitch_no_evt", 32'(n_events - ev0), 32'd0);

      // randomized patterns held for a few rounds each
      for (int r = 0; r < 8; r++) begin
         ra   = 16'($urandom & $urandom & $urandom);
         rb   = 16'($urandom & $urandom & $urandom);
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) run_round(ra, rb);
      end
      for (int h = 0; h < 3; h++) run_round(16'h0000, 16'h0000);

      // backpressure: keys 0 and 1 together with the consumer stalled
      evt_ready = 1'b0;
      run_round(16'h0003, 16'h0000);
      run_round(16'h0003, 16'h0000);
      p1_keys = 16'h0003;
      model_step(16'h0003, 16'h0000);
      for (int i = 0; i < 15; i++) tick();
      chk("bp_valid", {31'd0, evt_valid}, 32'd1);
      chk("bp_evt0", {26'd0, evt_player, evt_key, evt_press}, {26'd0, 6'b0_0000_1});
      chk("bp_row_held", {28'd0, p1_row}, 32'he);
      chk("bp_p2_row", {28'd0, p2_row}, 32'hf);
      chk("bp_ks_k0", {16'd0, ks1}, 32'h0001);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      chk("bp_valid_kept", {31'd0, evt_valid}, 32'd1);
      chk("bp_evt1", {26'd0, evt_player, evt_key, evt_press}, {26'd0, 6'b0_0001_1});
      chk("bp_ks_k1", {16'd0, ks1}, 32'h0003);
      evt_ready = 1'b1;
      wait_pulse(4 * ROUND_T);
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      for (int h = 0; h < 3; h++) run_round(16'h0000, 16'h0000);

      // scan enable dropped during P2 row 2 evaluation
      for (int h = 0; h < 3; h++) run_round(16'h0000, 16'h0200);
      chk("en_pre_ks2", {16'd0, ks2}, 32'h0200);
      model_step(16'h0000, 16'h0200);
      for (int i = 0; i < 6 * ROW_T + 5; i++) tick();
      scan_en = 1'b0;
      tick();
      chk("en_off_p1", {28'd0, p1_row}, 32'hF);
      chk("en_off_p2", {28'd0, p2_row}, 32'hF);
      for (int i = 0; i < 9; i++) tick();
      chk("en_off_p2_hold", {28'd0, p2_row}, 32'hF);
      chk("en_off_ks2", {16'd0, ks2}, 32'h0200);
      chk("en_off_ks1", {16'd0, ks1}, {16'd0, model_pack(0)});
      scan_en = 1'b1;
      tick();
      chk("en_resume_p2", {28'd0, p2_row}, 32'hB);
      chk("en_resume_p1", {28'd0, p1_row}, 32'hF);
      for (int j = 2; j <= 2 * ROW_T; j++) begin
         tick();
         chk("en_round_pulse", {31'd0, scan_round}, {31'd0, j == 2 * ROW_T});
      end
      chk("en_drained", 32'(exp_q.size()), 32'd0);

      // reset while an event is pending
      evt_ready = 1'b0;
      run_round(16'h8000, 16'h0200);
      run_round(16'h8000, 16'h0200);
      p1_keys = 16'h8000;
      model_step(16'h8000, 16'h0200);
      for (int i = 0; i < 40; i++) tick();
      chk("rst_pend_valid", {31'd0, evt_valid}, 32'd1);
      chk("rst_pend_key", {28'd0, evt_key}, 32'd15);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      p1_keys = 16'h0000;
      p2_keys = 16'h0000;
      model_reset();
      chk("rst2_valid", {31'd0, evt_valid}, 32'd0);
      chk("rst2_ks1", {16'd0, ks1}, 32'd0);
      chk("rst2_ks2", {16'd0, ks2}, 32'd0);
      chk("rst2_p2_row", {28'd0, p2_row}, 32'hF);
      evt_ready = 1'b1;
      run_round(16'h0000, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scan_scheduler.md
Name: keypad_scan_scheduler

Overview:
- Single scan sequencer that time-shares one settle/sample/debounce datapath between the Player 1 and Player 2 4×4 keypads.
- Drives the row strobes and samples the columns after a settle delay.
- Debounces all 32 keys and publishes a debounced key bitmap per player.
- Emits press/release events through a one-entry valid/ready slot.
- Sits between the keypad GPIO pins and the game input decode / character FSMs.

Parameters:
- SETTLE_CYCLES, 500: cycles a row is held low before the columns are captured (10 µs at 50 MHz).
- DB_COUNT, 4: consecutive scan rounds a key's raw level must differ from its debounced level before the debounced level flips.
- SETTLE_W, $clog2(SETTLE_CYCLES+1): width of the settle counter.
- DB_W, $clog2(DB_COUNT+1): width of each per-key debounce counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous, active-low reset.
- scan_en_i  in  1  scanning enable.
- p1_row_o  out  4  P1 row strobes, active-low.
- p1_col_i  in  4  P1 columns, active-low, asynchronous.
- p2_row_o  out  4  P2 row strobes, active-low.
- p2_col_i  in  4  P2 columns, active-low, asynchronous.
- key_state_p1_o  out  16  debounced P1 keys; bit = row*4+col; 1 = pressed.
- key_state_p2_o  out  16  debounced P2 keys, same encoding.
- evt_valid_o  out  1  event slot occupied.
- evt_ready_i  in  1  consumer accepts the event.
- evt_player_o  out  1  0 = P1, 1 = P2.
- evt_key_o  out  4  key index (row*4+col).
- evt_press_o  out  1  1 = press, 0 = release.
- scan_round_o  out  1  one-cycle pulse when P2 row 3 finishes (end of a full round).

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low (rst_ni sampled on the clk_i rising edge).
- Reset values:
  - rows 4'b1111 for both players.
  - key_state_* 0, all debounce counters 0.
  - evt_valid_o 0; evt_player/key/press 0.
  - scan_round_o 0.
  - FSM in S_SETTLE, player 0, row 0, settle counter 0.
- Column synchronizer: both column buses pass through 2-flop synchronizers, reset to 4'b1111.
- Row drive:
  - The active player's current row bit is 0.
  - All other bits of both row buses are 1.
  - Both buses are 4'b1111 when scan_en_i=0.
- S_SETTLE:
  - Settle counter increments each cycle.
  - When it reaches SETTLE_CYCLES-1, capture the active player's synchronized columns into col_sample, clear col_idx, go to S_EVAL.
  - Dwell is exactly SETTLE_CYCLES cycles.
- S_EVAL (one key per cycle, col_idx 0..3):
  - raw = ~col_sample[col_idx]; k = row*4+col_idx.
  - If raw == state[k]: counter[k] <= 0, advance.
  - Else if counter[k] < DB_COUNT-1: counter[k]++, advance.
  - Else (threshold reached):
    - If the slot is free (!evt_valid_o || evt_ready_i): flip state[k], counter[k] <= 0, load the event, advance.
    - Otherwise stall on this key: no state or counter change, row stays driven.
  - Advancing from col_idx 3 goes to S_ADVANCE.
- S_ADVANCE (1 cycle):
  - row++.
  - On the row 3 to 0 wrap, toggle the player.
  - Pulse scan_round_o when wrapping from P2 row 3.
  - Go to S_SETTLE.
- Nominal timing:
  - One row takes SETTLE_CYCLES+5 cycles.
  - One full round takes 8*(SETTLE_CYCLES+5) cycles.
  - A clean press is flagged DB_COUNT rounds after it first appears in a sample.
- Event slot:
  - evt_valid_o rises on load.
  - A transfer happens on the cycle where evt_valid_o && evt_ready_i.
  - A transfer and a new load in the same cycle are legal; the slot holds the new event, valid stays 1.
  - A transfer with no load clears evt_valid_o next cycle.
- key_state_* changes in the same cycle the event is loaded, never without an event.
- scan_en_i=0:
  - Force S_SETTLE with counter 0, keep the current row/player, rows 4'b1111.
  - Key states and debounce counters are held.
  - The event slot still drains.
  - Re-enable resumes at the held row with a full settle period.
- Reset mid-stall or mid-event: everything returns to reset values; a pending event is discarded.

Decomposition:
- Shared package keypad_pkg:
  - scan_state_e {S_SETTLE, S_EVAL, S_ADVANCE}.
  - key_idx_t (logic [3:0]).
  - player_e {PLAYER_1, PLAYER_2}.
  - key_evt_t struct {player, key, press}.
  - Key-index constants used by the game decode (LEFT, RIGHT, ATTACK, SELECT).
- Sub-module: col_sync (parameterised-width 2-flop synchronizer with synchronous active-low reset), instantiated once per keypad.

Test Plan (SETTLE_CYCLES=4, DB_COUNT=3; row = 9 cycles, round = 72 cycles):
- Reset, then scan_en_i=1, no keys:
  - rows cycle P1 1110, 1101, 1011, 0111, then P2 likewise, each row held 9 cycles.
  - scan_round_o pulses every 72 cycles.
  - no events.
- P1 key 5 (row 1, col 1) held, evt_ready_i=1:
  - exactly one event {player 0, key 5, press 1} after the 3rd round containing it.
  - key_state_p1_o = 16'h0020.
  - On release, one event {0, 5, 0} three rounds later; state returns to 0.
- Glitch: P2 key 10 held for 2 rounds, then released → no event; counter cleared; key_state_p2_o stays 0.
- Backpressure: evt_ready_i=0, P1 keys 0 and 1 pressed together:
  - event {0, 0, 1} is loaded.
  - FSM stalls at key 1 with p1_row_o=1110 held.
  - Raising evt_ready_i for 1 cycle transfers key 0 and loads {0, 1, 1} in the same cycle; evt_valid_o stays 1.
- scan_en_i dropped mid-S_EVAL on P2 row 2:
  - both row buses read 4'b1111.
  - key states are unchanged.
  - Re-enable resumes P2 row 2 after 4 settle cycles.
- Assert rst_ni=0 for 1 cycle while an event is pending: evt_valid_o=0, key_state_*=0, scanning restarts at P1 row 0.
